// File: rtl/setup_study_pkg.sv
`timescale 1ps/1fs
// Shared constants and helpers for the setup-time characterisation board.
// Every time value inside the board is kept in picoseconds.
package setup_study_pkg;

  localparam real PS_PER_S = 1.0e12;
  localparam real FF_PER_F = 1.0e15;

  // Margins closer than this are below the 1 fs time resolution.
  localparam real EPS_PS   = 1.0e-6;
  localparam real PULSE_PS = 0.001;

  function automatic real ramp_mid_ps(input real tt_s);
    real tt_ps;
    tt_ps = tt_s * PS_PER_S;
    return (tt_ps > 0.0) ? (tt_ps / 2.0) : 0.0;
  endfunction

endpackage

// File: rtl/edge_ramp_model.sv
`timescale 1ps/1fs
// Turns an ideal digital edge into a 50% crossing event half a transition time later.
// The transition time is sampled at the digital edge.
module edge_ramp_model
  import setup_study_pkg::*;
(
  input  logic sig_i,
  input  real  tt_i,
  input  logic rst_n_i,
  output logic cross_o,
  output real  cross_time_ps_o,
  output logic cross_level_o,
  output real  cross_tt_ps_o
);

  int unsigned gen_q;
  logic        sig_q;

  task automatic launch(input real mid_ps, input logic level, input int unsigned gen);
    #(mid_ps);
    if (gen == gen_q) begin
      cross_time_ps_o = $realtime;
      cross_level_o   = level;
      cross_tt_ps_o   = 2.0 * mid_ps;
      cross_o         = 1'b1;
      #(PULSE_PS);
      cross_o         = 1'b0;
    end
  endtask

  // A new edge or a reset bumps the generation, so older in-flight ramps never report.
  always @(sig_i or rst_n_i) begin
    if (!rst_n_i) begin
      gen_q           = gen_q + 1;
      sig_q           = sig_i;
      cross_o         = 1'b0;
      cross_time_ps_o = 0.0;
      cross_level_o   = sig_i;
      cross_tt_ps_o   = 0.0;
    end else if (sig_i !== sig_q) begin
      gen_q = gen_q + 1;
      sig_q = sig_i;
      fork
        launch(ramp_mid_ps(tt_i), sig_i, gen_q);
      join_none
    end
  end

endmodule

// File: rtl/setup_study_bd.sv
`timescale 1ps/1fs
// Characterisation board: D flop with QN output, slope-dependent setup window
// and load-dependent clk-to-q delay, timestamping the clk/din 50% crossings.
module setup_study_bd
  import setup_study_pkg::*;
#(
  parameter real SETUP_BASE_PS   = 30.0,
  parameter real K_SETUP_CLK     = 0.5,
  parameter real K_SETUP_D       = 0.5,
  parameter real TCQ_BASE_PS     = 60.0,
  parameter real K_TCQ_PS_PER_FF = 2.0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  real  tt_val_clk,
  input  real  tt_val_d,
  input  real  capa_charge_val,
  input  logic fin_test,
  output logic dout,
  output real  clk_rise_time,
  output real  d_rise_time
);

  logic clk_x, clk_x_lvl, din_x, din_x_lvl;
  real  clk_x_ps, clk_x_tt_ps, din_x_ps, din_x_tt_ps;

  real         d_cross_q, d_tt_q;
  logic        d_level_q, d_prev_q;
  logic        stored_q;
  int unsigned tcq_gen_q;
  bit          summary_done_q;

  edge_ramp_model u_clk_ramp (
    .sig_i          (clk),
    .tt_i           (tt_val_clk),
    .rst_n_i        (rst_n),
    .cross_o        (clk_x),
    .cross_time_ps_o(clk_x_ps),
    .cross_level_o  (clk_x_lvl),
    .cross_tt_ps_o  (clk_x_tt_ps)
  );

  edge_ramp_model u_din_ramp (
    .sig_i          (din),
    .tt_i           (tt_val_d),
    .rst_n_i        (rst_n),
    .cross_o        (din_x),
    .cross_time_ps_o(din_x_ps),
    .cross_level_o  (din_x_lvl),
    .cross_tt_ps_o  (din_x_tt_ps)
  );

  // Out of reset no din crossing has been seen, so the first clk edge sees an
  // unlimited margin and captures the reset level 1.
  always @(din_x or rst_n) begin
    if (!rst_n) begin
      d_cross_q   = -1.0e30;
      d_tt_q      = 0.0;
      d_level_q   = 1'b1;
      d_prev_q    = 1'b1;
      d_rise_time = 0.0;
    end else if (din_x && !fin_test) begin
      d_prev_q    = d_level_q;
      d_level_q   = din_x_lvl;
      d_cross_q   = din_x_ps;
      d_tt_q      = din_x_tt_ps;
      d_rise_time = din_x_ps / PS_PER_S;
    end
  end

  task automatic apply_dout(input real delay_ps, input logic level, input int unsigned gen);
    #(delay_ps);
    if (gen == tcq_gen_q && rst_n && !fin_test) dout = level;
  endtask

  // Only the newest scheduled clk-to-q update may land; reset and fin_test retire the rest.
  always @(clk_x or rst_n or fin_test) begin : capture
    real t_setup_d, margin_d, tcq_d;
    if (!rst_n) begin
      tcq_gen_q     = tcq_gen_q + 1;
      stored_q      = 1'b1;
      dout          = 1'b0;
      clk_rise_time = 0.0;
    end else if (fin_test) begin
      tcq_gen_q = tcq_gen_q + 1;
    end else if (clk_x && clk_x_lvl) begin
      clk_rise_time = clk_x_ps / PS_PER_S;
      t_setup_d = SETUP_BASE_PS + K_SETUP_CLK * clk_x_tt_ps + K_SETUP_D * d_tt_q;
      margin_d  = clk_x_ps - d_cross_q;
      // A din crossing coincident with the clk crossing counts as a violation.
      if (margin_d > EPS_PS && margin_d >= t_setup_d - EPS_PS) stored_q = d_level_q;
      else                                                      stored_q = d_prev_q;
      tcq_d = TCQ_BASE_PS + K_TCQ_PS_PER_FF *
              ((capa_charge_val > 0.0) ? capa_charge_val * FF_PER_F : 0.0);
      tcq_gen_q = tcq_gen_q + 1;
      fork
        apply_dout(tcq_d, ~stored_q, tcq_gen_q);
      join_none
    end
  end

  always @(posedge fin_test) begin
    if (!summary_done_q) begin
      summary_done_q <= 1'b1;
      $display("[setup_study_bd] fin_test: dout=%b clk_rise_time=%.6e d_rise_time=%.6e",
               dout, clk_rise_time, d_rise_time);
    end
  end

endmodule

// File: tb/tb_setup_study_bd.sv
`timescale 1ps/1fs
// Directed bench for setup_study_bd: slope/offset vector table plus hand-written
// reset-inside-TCQ and fin_test freeze sequences.
module tb_setup_study_bd;

  logic clk, rst_n, din, fin_test, dout;
  real  tt_val_clk, tt_val_d, capa_charge_val, clk_rise_time, d_rise_time;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    real  ttS;
    real  capaF;
    real  offsetPs;
    real  midPs;
    real  tcqPs;
    logic expDout;
  } vec_t;

  vec_t vecs[7];

  setup_study_bd dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .din            (din),
    .tt_val_clk     (tt_val_clk),
    .tt_val_d       (tt_val_d),
    .capa_charge_val(capa_charge_val),
    .fin_test       (fin_test),
    .dout           (dout),
    .clk_rise_time  (clk_rise_time),
    .d_rise_time    (d_rise_time)
  );

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic checkReal(input string name, input real actual, input real expected, input real tol);
    real diff;
    nChecks++;
    diff = actual - expected;
    if (diff < 0.0) diff = -diff;
    if (diff > tol) begin
      nFails++;
      $display("[TB] FAIL %s: got %.9e, expected %.9e", name, actual, expected);
    end
  endtask

  // Leaves the flop holding D=1 (dout=0) with clk low and din high.
  task automatic primeOne();
    din = 1'b1;
    #1000;
    clk = 1'b1;
    #1000;
    clk = 1'b0;
    #1000;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    real tD, tC;
    tt_val_clk      = v.ttS;
    tt_val_d        = v.ttS;
    capa_charge_val = v.capaF;
    primeOne();
    checkOutput($sformatf("vec%0d primed dout", idx), dout, 1'b0);
    tD  = $realtime;
    din = 1'b0;
    #(v.offsetPs);
    tC  = $realtime;
    clk = 1'b1;
    #(v.midPs + v.tcqPs - 0.5);
    checkOutput($sformatf("vec%0d dout before tcq", idx), dout, 1'b0);
    #1;
    checkOutput($sformatf("vec%0d dout after tcq", idx), dout, v.expDout);
    checkReal($sformatf("vec%0d clk_rise_time", idx), clk_rise_time, (tC + v.midPs) * 1.0e-12, 1.0e-15);
    checkReal($sformatf("vec%0d d_rise_time", idx), d_rise_time, (tD + v.midPs) * 1.0e-12, 1.0e-15);
    checkReal($sformatf("vec%0d clk-d delta", idx), clk_rise_time - d_rise_time, v.offsetPs * 1.0e-12, 1.0e-15);
    clk = 1'b0;
    #1000;
  endtask

  initial begin
    real tC, tD, expClk, expD;

    //          ttS          capaF       offsetPs  midPs     tcqPs   expDout
    vecs[0] = '{1.17378e-12, 60.73e-15,  200.0,    0.58689,  181.46, 1'b1};
    vecs[1] = '{1.17378e-12, 60.73e-15,  10.0,     0.58689,  181.46, 1'b0};
    vecs[2] = '{198.535e-12, 60.73e-15,  228.535,  99.2675,  181.46, 1'b1};
    vecs[3] = '{198.535e-12, 60.73e-15,  228.0,    99.2675,  181.46, 1'b0};
    vecs[4] = '{0.0,         0.0,        30.0,     0.0,      60.0,   1'b1};
    vecs[5] = '{-5.0e-12,    -10.0e-15,  29.9,     0.0,      60.0,   1'b0};
    vecs[6] = '{-5.0e-12,    -10.0e-15,  30.0,     0.0,      60.0,   1'b1};

    rst_n           = 1'b0;
    clk             = 1'b0;
    din             = 1'b1;
    fin_test        = 1'b0;
    tt_val_clk      = 1.17378e-12;
    tt_val_d        = 1.17378e-12;
    capa_charge_val = 60.73e-15;
    #100;
    checkOutput("reset dout", dout, 1'b0);
    checkReal("reset clk_rise_time", clk_rise_time, 0.0, 0.0);
    checkReal("reset d_rise_time", d_rise_time, 0.0, 0.0);

    rst_n = 1'b1;
    #500;
    tC  = $realtime;
    clk = 1'b1;
    #500;
    checkOutput("din=1 held dout", dout, 1'b0);
    checkOutput("clk_rise_time positive", clk_rise_time > 0.0, 1'b1);
    checkReal("first clk_rise_time", clk_rise_time, (tC + 0.58689) * 1.0e-12, 1.0e-15);
    clk = 1'b0;
    #500;

    for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

    // Reset lands 50 ps after a capturing clk crossing, inside the 181.46 ps TCQ.
    tt_val_clk      = 1.17378e-12;
    tt_val_d        = 1.17378e-12;
    capa_charge_val = 60.73e-15;
    primeOne();
    din = 1'b0;
    #300;
    clk = 1'b1;
    #(0.58689 + 50.0);
    rst_n = 1'b0;
    #1;
    checkOutput("reset in tcq dout", dout, 1'b0);
    checkReal("reset in tcq clk_rise_time", clk_rise_time, 0.0, 0.0);
    checkReal("reset in tcq d_rise_time", d_rise_time, 0.0, 0.0);
    #10;
    rst_n = 1'b1;
    #400;
    checkOutput("no late update after reset", dout, 1'b0);
    clk = 1'b0;
    #1000;

    // fin_test arrives with a capture still pending; everything must freeze.
    primeOne();
    tD  = $realtime;
    din = 1'b0;
    #300;
    tC  = $realtime;
    clk = 1'b1;
    #10;
    fin_test = 1'b1;
    expClk = (tC + 0.58689) * 1.0e-12;
    expD   = (tD + 0.58689) * 1.0e-12;
    #400;
    checkOutput("fin pending capture dropped", dout, 1'b0);
    clk = 1'b0;
    #200;
    din = 1'b1;
    #200;
    clk = 1'b1;
    #200;
    din = 1'b0;
    #300;
    clk = 1'b0;
    #500;
    checkOutput("fin frozen dout", dout, 1'b0);
    checkReal("fin frozen clk_rise_time", clk_rise_time, expClk, 1.0e-15);
    checkReal("fin frozen d_rise_time", d_rise_time, expD, 1.0e-15);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
